// File: rtl/button_cmd_queue_if.sv
// CPU-side read port of the button command queue.
// The master is the CPU IO-read path; the slave is the queue.
interface button_cmd_queue_if;
   logic        rd_en;
   logic [31:0] cmd_out;
   logic        cmd_valid;
   logic        overflow;

   modport master (
      output rd_en,
      input  cmd_out,
      input  cmd_valid,
      input  overflow
   );

   modport slave (
      input  rd_en,
      output cmd_out,
      output cmd_valid,
      output overflow
   );
endinterface

// File: rtl/button_cmd_queue.sv
// Turns raw BTNU/BTND pads into queued one-shot hit(1)/stand(2) commands popped by CPU loads.
// Define BTN_CMD_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding slot is used.
module button_cmd_queue #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              btn_u,
   input  logic              btn_d,
   button_cmd_queue_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]       CMD_HIT   = 2'd1;
   localparam logic [1:0]       CMD_STAND = 2'd2;

   generate
      if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
         $error("CNT_W too narrow for DEBOUNCE_CYCLES");
      end
      if ((FIFO_DEPTH < 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("FIFO_DEPTH must be a power of two");
      end
   endgenerate

   // Bit 0 is BTNU, bit 1 is BTND throughout the conditioning path.
   logic [1:0]       pad_s;
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [1:0]       stable_q, stable_d;
   logic [1:0]       prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];

   logic [1:0]       press_s;
   logic             push_s;
   logic [1:0]       push_cmd_s;

   logic             valid_s;
   logic [1:0]       head_s;
   logic             ovf_hit_s;
   logic             overflow_q, overflow_d;

   assign pad_s = {btn_d, btn_u};

   // Synchroniser and debounce next-state for both buttons.
   always_comb begin
      sync1_d  = pad_s;
      sync2_d  = sync1_q;
      prev_d   = stable_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
               cnt_d[i]    = '0;
            end else begin
               cnt_d[i]    = cnt_q[i] + CNT_W'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   // Synchroniser, debounce and edge-detect state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q  <= 2'b00;
         sync2_q  <= 2'b00;
         stable_q <= 2'b00;
         prev_q   <= 2'b00;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
      end
   end

   // Simultaneous U and D presses cancel, mirroring the legacy XOR of the raw buttons.
   assign press_s    = stable_q & ~prev_q;
   assign push_s     = press_s[0] ^ press_s[1];
   assign push_cmd_s = press_s[0] ? CMD_HIT : CMD_STAND;

`ifdef BTN_CMD_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W = PTR_W - 1;

   generate
      if (FIFO_DEPTH < 2) begin : g_bad_fifo_depth
         $error("FIFO build needs FIFO_DEPTH of at least 2");
      end
   endgenerate

   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [1:0]       mem_q [FIFO_DEPTH];
   logic [1:0]       mem_d [FIFO_DEPTH];
   logic             empty_s, full_s, pop_s, push_ok_s;

   assign empty_s = (wr_q == rd_q);
   assign full_s  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                    (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
   assign valid_s = ~empty_s;
   assign head_s  = mem_q[rd_q[IDX_W-1:0]];

   // A pop in the same cycle frees the slot a full-queue push overwrites.
   always_comb begin
      pop_s     = bus.rd_en & ~empty_s;
      push_ok_s = push_s & (~full_s | pop_s);
      ovf_hit_s = push_s & full_s & ~pop_s;
      wr_d      = push_ok_s ? (wr_q + PTR_W'(1)) : wr_q;
      rd_d      = pop_s ? (rd_q + PTR_W'(1)) : rd_q;
      mem_d     = mem_q;
      if (push_ok_s) begin
         mem_d[wr_q[IDX_W-1:0]] = push_cmd_s;
      end else begin
         mem_d[wr_q[IDX_W-1:0]] = mem_q[wr_q[IDX_W-1:0]];
      end
   end

   // Circular queue storage and pointers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 2'd0;
         end
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end
`else
   logic       slot_vld_q, slot_vld_d;
   logic [1:0] slot_q, slot_d;
   logic       pop_s, push_ok_s;

   assign valid_s = slot_vld_q;
   assign head_s  = slot_q;

   // Capacity-one queue: same push/pop/overflow rules as the FIFO with depth 1.
   always_comb begin
      pop_s      = bus.rd_en & slot_vld_q;
      push_ok_s  = push_s & (~slot_vld_q | pop_s);
      ovf_hit_s  = push_s & slot_vld_q & ~pop_s;
      slot_d     = push_ok_s ? push_cmd_s : slot_q;
      if (push_ok_s) begin
         slot_vld_d = 1'b1;
      end else if (pop_s) begin
         slot_vld_d = 1'b0;
      end else begin
         slot_vld_d = slot_vld_q;
      end
   end

   // Holding register and its valid flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_vld_q <= 1'b0;
         slot_q     <= 2'd0;
      end else begin
         slot_vld_q <= slot_vld_d;
         slot_q     <= slot_d;
      end
   end
`endif

   assign overflow_d = overflow_q | ovf_hit_s;

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   // Head is presented with no read latency so the CPU load sees it in the rd_en cycle.
   assign bus.cmd_valid = valid_s;
   assign bus.cmd_out   = valid_s ? {30'd0, head_s} : 32'd0;
   assign bus.overflow  = overflow_q;
endmodule
